// File: rtl/matvec_pkg.sv
// Shared constants and state encoding for the matrix-vector output path.
package matvec_pkg;

  localparam int R_DEF       = 8;
  localparam int C_DEF       = 8;
  localparam int W_X_DEF     = 8;
  localparam int W_K_DEF     = 8;
  localparam int W_Y_DEF     = W_X_DEF + W_K_DEF + $clog2(C_DEF);
  localparam int LATENCY_DEF = $clog2(C_DEF) + 1;
  localparam int BPY_DEF     = (W_Y_DEF + 7) / 8;

  localparam logic [7:0] HDR_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    SEND = 2'd2
  } state_e;

endpackage

// File: rtl/matvec_axis_out_if.sv
// Byte-wide AXI-Stream link from the result serializer toward the UART TX path.
interface matvec_axis_out_if;

  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/y_byte_serializer.sv
// Latches one result vector and streams it out as sign-extended little-endian bytes.
// Define MATVEC_AXIS_OUT_HDR_EN to prefix every frame with HDR_BYTE.
module y_byte_serializer
  import matvec_pkg::*;
#(
  parameter int R   = R_DEF,
  parameter int W_Y = W_Y_DEF,
  parameter int BPY = BPY_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [R*W_Y-1:0]     y_in,
  output logic                 busy,
  matvec_axis_out_if.master    m_axis
);

  // state   | meaning
  // IDLE    | buffer empty, waiting for load
  // HDR     | presenting the sync byte (header build only)
  // SEND    | presenting result bytes, word by word

  localparam int WW = (R > 1) ? $clog2(R) : 1;
  localparam int BW = (BPY > 1) ? $clog2(BPY) : 1;
  localparam logic [WW-1:0] WORD_LAST = WW'(R - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(BPY - 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_HDR  = HDR;
  localparam logic [1:0] ST_SEND = SEND;

  logic [1:0]       state_q;
  logic             busy_q;
  logic             tvalid_q;
  logic [WW-1:0]    word_q;
  logic [BW-1:0]    byte_q;
  logic [W_Y-1:0]   buf_q [R];
  logic [BPY*8-1:0] ext;
  logic [7:0]       tdata_c;
  logic             hs;

  assign hs   = tvalid_q & m_axis.tready;
  assign busy = busy_q;

  always_ff @(posedge clk) begin
    if (load && (state_q == ST_IDLE)) begin
      for (int r = 0; r < R; r++) begin
        buf_q[r] <= y_in[r*W_Y +: W_Y];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      tvalid_q <= 1'b0;
      word_q   <= '0;
      byte_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            busy_q   <= 1'b1;
            tvalid_q <= 1'b1;
            word_q   <= '0;
            byte_q   <= '0;
`ifdef MATVEC_AXIS_OUT_HDR_EN
            state_q  <= ST_HDR;
`else
            state_q  <= ST_SEND;
`endif
          end
        end
        ST_HDR: begin
          if (hs) state_q <= ST_SEND;
        end
        ST_SEND: begin
          if (hs) begin
            if (byte_q == BYTE_LAST) begin
              byte_q <= '0;
              if (word_q == WORD_LAST) begin
                word_q   <= '0;
                tvalid_q <= 1'b0;
                busy_q   <= 1'b0;
                state_q  <= ST_IDLE;
              end else begin
                word_q <= word_q + 1'b1;
              end
            end else begin
              byte_q <= byte_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode only from registers, so they hold steady while the sink stalls.
  always_comb begin
    ext     = (BPY*8)'($signed(buf_q[word_q]));
    tdata_c = 8'h00;
    if (state_q == ST_HDR) begin
      tdata_c = HDR_BYTE;
    end else if (state_q == ST_SEND) begin
      for (int b = 0; b < BPY; b++) begin
        if (byte_q == BW'(b)) tdata_c = ext[b*8 +: 8];
      end
    end
  end

  assign m_axis.tdata  = tdata_c;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = (state_q == ST_SEND) && (word_q == WORD_LAST) && (byte_q == BYTE_LAST);

endmodule

// File: rtl/matvec_axis_out.sv
// Output companion to the pipelined matrix-vector multiplier: tracks stage validity,
// drives cen, and streams results over AXI-Stream. Header option: MATVEC_AXIS_OUT_HDR_EN.
module matvec_axis_out
  import matvec_pkg::*;
#(
  parameter int R   = R_DEF,
  parameter int C   = C_DEF,
  parameter int W_X = W_X_DEF,
  parameter int W_K = W_K_DEF,
  localparam int W_Y     = W_X + W_K + $clog2(C),
  localparam int LATENCY = $clog2(C) + 1,
  localparam int BPY     = (W_Y + 7) / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              cen,
  input  logic [R*W_Y-1:0]  y,
  matvec_axis_out_if.master m_axis
);

  logic [LATENCY-1:0] pipe_v;
  logic               busy;
  logic               stall;
  logic               load;

  // A finished result with nowhere to go freezes the whole multiplier.
  assign stall   = pipe_v[LATENCY-1] & busy;
  assign cen     = ~stall;
  assign s_ready = cen;
  assign load    = pipe_v[LATENCY-1] & ~busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v <= '0;
    end else if (cen) begin
      pipe_v <= {pipe_v[LATENCY-2:0], s_valid};
    end
  end

  y_byte_serializer #(
    .R   (R),
    .W_Y (W_Y),
    .BPY (BPY)
  ) u_ser (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .y_in   (y),
    .busy   (busy),
    .m_axis (m_axis)
  );

endmodule

// File: tb/tb_matvec_axis_out.sv
// Scoreboard bench for matvec_axis_out with a behavioural cen-gated multiplier model.
module tb_matvec_axis_out;
  import matvec_pkg::*;

  localparam int R   = R_DEF;
  localparam int C   = C_DEF;
  localparam int W_Y = W_Y_DEF;
  localparam int BPY = BPY_DEF;
  localparam int LAT = LATENCY_DEF;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic             cen;
  logic [R*W_Y-1:0] y;

  matvec_axis_out_if axis();

  matvec_axis_out dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .cen     (cen),
    .y       (y),
    .m_axis  (axis)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   frames = 0;
  int   bytes_seen = 0;
  bit   rand_rdy = 1'b0;
  int   cur_x [C];
  int   cur_k [R][C];
  logic [R*W_Y-1:0] ystage [LAT];

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_true(input string tag, input bit cond);
    checks++;
    assert (cond) else begin
      failures++;
      $error("FAIL %s observed=0 expected=1", tag);
    end
  endtask

  function automatic int row_sum(input int r);
    int acc = 0;
    for (int c = 0; c < C; c++) acc += cur_x[c] * cur_k[r][c];
    return acc;
  endfunction

  function automatic logic [R*W_Y-1:0] mult_now();
    logic [R*W_Y-1:0] v;
    int s;
    v = '0;
    for (int r = 0; r < R; r++) begin
      s = row_sum(r);
      v[r*W_Y +: W_Y] = s[W_Y-1:0];
    end
    return v;
  endfunction

  // Multiplier stand-in: LAT stages, frozen whenever cen is low.
  always @(posedge clk) begin
    if (cen === 1'b1) begin
      ystage[0] <= mult_now();
      for (int i = 1; i < LAT; i++) ystage[i] <= ystage[i-1];
    end
  end
  assign y = ystage[LAT-1];

  task automatic push_expected();
    exp_t e;
    int   s;
`ifdef MATVEC_AXIS_OUT_HDR_EN
    e.d = 8'hA5;
    e.l = 1'b0;
    q.push_back(e);
`endif
    for (int r = 0; r < R; r++) begin
      s = row_sum(r);
      for (int b = 0; b < BPY; b++) begin
        e.d = 8'((s >>> (8*b)) & 255);
        e.l = (r == R-1) && (b == BPY-1);
        q.push_back(e);
      end
    end
  endtask

  // Output monitor: sampled on the falling edge, handshake lands on the next rising edge.
  logic       prev_hold = 1'b0;
  logic [7:0] prev_d;
  logic       prev_l;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_hold  = 1'b0;
      bytes_seen = 0;
    end else begin
      if (prev_hold) begin
        check32("hold_tvalid", 32'(axis.tvalid), 32'd1);
        check32("hold_tdata", 32'(axis.tdata), 32'(prev_d));
        check32("hold_tlast", 32'(axis.tlast), 32'(prev_l));
      end
      if (axis.tvalid === 1'b1 && axis.tready === 1'b1) begin
        check_true("unexpected_byte", q.size() != 0);
        if (q.size() != 0) begin
          e = q.pop_front();
          check32("tdata", 32'(axis.tdata), 32'(e.d));
          check32("tlast", 32'(axis.tlast), 32'(e.l));
        end
        bytes_seen++;
        if (axis.tlast === 1'b1) begin
          frames++;
          bytes_seen = 0;
        end
      end
      prev_hold = (axis.tvalid === 1'b1) && (axis.tready !== 1'b1);
      prev_d    = axis.tdata;
      prev_l    = axis.tlast;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) axis.tready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_vec();
    int n = 0;
    bit done = 1'b0;
    s_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (s_ready === 1'b1) begin
        push_expected();
        done = 1'b1;
      end
      tick();
      n++;
      if (!done && n > 500) begin
        check_true("accept_timeout", 1'b0);
        done = 1'b1;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check_true("drain_timeout", q.size() == 0);
    repeat (3) tick();
  endtask

  initial begin
    int n;
    for (int i = 0; i < LAT; i++) ystage[i] = '0;
    for (int c = 0; c < C; c++) cur_x[c] = 0;
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) cur_k[r][c] = 0;
    axis.tready = 1'b1;

    // Reset held three cycles
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check32("rst_tvalid", 32'(axis.tvalid), 32'd0);
    check32("rst_tlast", 32'(axis.tlast), 32'd0);
    check32("rst_tdata", 32'(axis.tdata), 32'd0);
    check32("rst_cen", 32'(cen), 32'd1);
    check32("rst_s_ready", 32'(s_ready), 32'd1);
    tick();

    // Single vector: x all 1, row r of k all r -> y[r] = 8r
    for (int c = 0; c < C; c++) cur_x[c] = 1;
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) cur_k[r][c] = r;
    send_vec();
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check32("latency_tvalid", 32'(axis.tvalid), (i == 5) ? 32'd1 : 32'd0);
    end
    wait_drain(200);
    check32("frames_single", 32'(frames), 32'd1);

    // Negative result: 8 * (127 * -1) = -1016 -> 08 FC FF
    for (int c = 0; c < C; c++) cur_x[c] = 127;
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) cur_k[r][c] = -1;
    send_vec();
    wait_drain(200);
    check32("frames_neg", 32'(frames), 32'd2);

    // Backpressure: three back-to-back vectors against a stalled sink
    axis.tready = 1'b0;
    for (int v = 0; v < 3; v++) begin
      for (int c = 0; c < C; c++) cur_x[c] = v + 2;
      for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) cur_k[r][c] = r - c - v;
      send_vec();
    end
    @(negedge clk);
    check32("bp_ready_a", 32'(s_ready), 32'd1);
    @(negedge clk);
    check32("bp_ready_b", 32'(s_ready), 32'd1);
    @(negedge clk);
    check32("bp_ready_stall", 32'(s_ready), 32'd0);
    check32("bp_cen_stall", 32'(cen), 32'd0);
    repeat (17) tick();
    @(negedge clk);
    check32("bp_still_stalled", 32'(s_ready), 32'd0);
    check32("bp_tvalid_held", 32'(axis.tvalid), 32'd1);
    tick();
    axis.tready = 1'b1;
    wait_drain(400);
    check32("frames_bp", 32'(frames), 32'd5);

    // Random readiness over ten random frames
    rand_rdy = 1'b1;
    for (int f = 0; f < 10; f++) begin
      for (int c = 0; c < C; c++) cur_x[c] = int'($urandom_range(0, 255)) - 128;
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) cur_k[r][c] = int'($urandom_range(0, 255)) - 128;
      send_vec();
    end
    wait_drain(3000);
    rand_rdy = 1'b0;
    axis.tready = 1'b1;
    check32("frames_rand", 32'(frames), 32'd15);

    // Reset in the middle of a frame, then a clean frame
    for (int c = 0; c < C; c++) cur_x[c] = 3;
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) cur_k[r][c] = r + 1;
    send_vec();
    n = 0;
    while (bytes_seen != 9 && n < 100) begin
      tick();
      n++;
    end
    check32("midrst_reach_byte10", 32'(bytes_seen), 32'd9);
    rst = 1'b1;
    q.delete();
    tick();
    @(negedge clk);
    check32("midrst_tvalid", 32'(axis.tvalid), 32'd0);
    check32("midrst_tlast", 32'(axis.tlast), 32'd0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < C; c++) cur_x[c] = 2;
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) cur_k[r][c] = (r == 0) ? -5 : r;
    send_vec();
    wait_drain(200);
    check32("frames_after_rst", 32'(frames), 32'd16);
    check32("bytes_after_rst", 32'(bytes_seen), 32'd0);
    check32("final_queue", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matvec_axis_out.md
Name: matvec_axis_out

Overview:
- Output-side companion to the pipelined matrix-vector multiplier.
- Drives the multiplier's `cen` and tracks which pipeline stages hold valid data.
- Captures each finished result vector `y` and serializes it as little-endian bytes on an AXI-Stream master toward the UART TX path.
- Applies backpressure by stalling the whole multiplier pipeline through `cen`, so no result is lost or duplicated.

Parameters:
- R, 8, rows of k; number of y words per frame.
- C, 8, columns of k; sets adder-tree depth.
- W_X, 8, x element width.
- W_K, 8, k element width.
- W_Y, W_X+W_K+$clog2(C) (=19), y word width; derived localparam.
- LATENCY, $clog2(C)+1 (=4), multiplier cen-cycles from input to y; derived localparam.
- BPY, (W_Y+7)/8 (=3), bytes per y word; derived localparam.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- s_valid  in  1  x/k presented to the multiplier this cycle.
- s_ready  out  1  vector accepted when s_valid && s_ready; equals cen.
- cen  out  1  multiplier clock enable.
- y  in  R*W_Y  multiplier result, signed, packed with row 0 in the LSBs.
- m_axis_tdata  out  8  output byte.
- m_axis_tvalid  out  1  byte valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last byte of frame.

Behaviour:
- Reset values:
  - pipe_v[LATENCY-1:0]=0, busy=0, state=IDLE.
  - Word and byte counters = 0.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - cen=1 and s_ready=1 from the first cycle after reset.
- Stall logic:
  - stall = pipe_v[LATENCY-1] && busy. Registered sources only; no combinational path from tready.
  - cen = s_ready = !stall.
- Valid pipeline (advances only when cen=1):
  - pipe_v[0] <= s_valid.
  - pipe_v[i] <= pipe_v[i-1].
  - pipe_v[i]=1 means tree stage i holds valid data; pipe_v[LATENCY-1] means y is valid now.
  - When cen=0, pipe_v holds, and y holds because the multiplier is frozen.
- Capture:
  - Condition: pipe_v[LATENCY-1] && !busy.
  - Action: latch y into buffer, busy<=1, state<=SEND, tvalid<=1, word=0, byte=0.
  - cen is 1 that cycle, so the pipeline advances in the same edge.
- Serializer FSM, states IDLE and SEND:
  - In SEND, tdata = byte[byte] of sign-extended buf[word]. Extension is to BPY*8 bits, little-endian, so byte 0 is the LSB.
  - On tvalid && tready:
    - if byte==BPY-1: byte=0, word++;
    - else: byte++.
  - tlast=1 exactly on word==R-1 && byte==BPY-1.
  - On the last handshake: tvalid<=0, busy<=0, state<=IDLE.
  - A pending result is captured on the following edge, giving one bubble cycle between frames.
- AXI rules:
  - tdata and tlast are stable while tvalid && !tready.
  - tvalid never drops without a handshake, except on rst.
- Throughput:
  - A new vector every cycle is accepted until the pipeline fills behind a busy buffer.
  - Up to LATENCY vectors plus 1 buffered frame can be in flight.
- rst mid-frame:
  - The frame is dropped and pipe_v is cleared.
  - Stale multiplier contents are ignored because they are marked invalid.
  - The first post-reset frame starts at word 0, byte 0.
- Simultaneous s_valid and stall: the vector is not accepted. The producer holds s_valid and data.

Optional Feature:
- Macro MATVEC_AXIS_OUT_HDR_EN.
- When defined:
  - Each frame is prefixed with sync byte 8'hA5, adding a HDR state before SEND.
  - Frame length is R*BPY+1 bytes; tlast position is unchanged.
- When undefined:
  - No header; frame length is R*BPY bytes.

Decomposition:
- Shared package matvec_pkg holds:
  - R, C, W_X, W_K defaults.
  - Derived W_Y, LATENCY, BPY.
  - Header constant HDR_BYTE=8'hA5.
  - State enum {IDLE, HDR, SEND}.
- One sub-module: y_byte_serializer.
  - Contains the buffer, counters, FSM and AXIS outputs.
  - Interface: load/busy in, AXIS out.
- The valid pipeline and cen logic stay in the top.

Test Plan (R=C=8, W_X=W_K=8, so W_Y=19, BPY=3, LATENCY=4):
- Reset: hold rst 3 cycles, then release -> tvalid=0, tlast=0, cen=1, s_ready=1.
- Single vector, x all 1, k row r all r, tready=1 -> 24 bytes.
  - y[1] gives 08 00 00; y[7] gives 38 00 00.
  - tlast only on byte 24.
  - tvalid first high 5 cycles after the accepting edge.
- Negative result, x=127, k=-1 -> each word = -1016, bytes 08 FC FF; sign extension is correct.
- Backpressure: 3 back-to-back vectors with tready=0 for 20 cycles -> cen/s_ready fall once the second result reaches stage 3.
  - After release: 72 bytes in order, 3 tlast pulses, no loss or duplication.
- Random tready at 50% over 10 frames -> tdata/tlast stable whenever tvalid && !tready, and the scoreboard matches.
- rst asserted at byte 10 of a frame -> tvalid=0 next cycle; the following vector produces a clean 24-byte frame starting at y[0] byte 0.
